// File: rtl/tx_framer.sv
// Frame serialiser for the Tx modulator: buffers one AXI-Stream byte packet, then emits
// preamble, header {mode,len}, payload and CRC-8 one bit per symbol strobe.
module tx_framer #(
    parameter logic [31:0] PREAMBLE = 32'h1ACF_FC1D,
    parameter int          MAX_LEN  = 15,
    parameter int          GAP_BITS = 16
) (
    input  logic       clk_32M768,
    input  logic       rst_32M768,
    input  logic       sym_en,
    input  logic [3:0] MODE_CTRL,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    input  logic       s_tlast,
    output logic       s_tready,
    output logic       tx_serial,
    output logic       tx_valid,
    output logic       tx_sof,
    output logic       ovf
);

    typedef enum logic [2:0] {
        IDLE, LOAD, DISCARD, SEND_PRE, SEND_HDR, SEND_PAY, SEND_CRC, GAP
    } state_t;

    state_t      r_state;
    logic [7:0]  r_buf [MAX_LEN];
    logic [3:0]  r_wr_ptr;
    logic [3:0]  r_len;
    logic [3:0]  r_idx;
    logic [7:0]  r_hdr;
    logic [7:0]  r_crc;
    logic [15:0] r_cnt;
    logic        r_tready;
    logic        r_tx_serial;
    logic        r_tx_valid;
    logic        r_tx_sof;
    logic        r_ovf;

    logic        w_acc;
    logic        w_loading;
    logic        w_hdr_bit;
    logic [7:0]  w_pay_byte;
    logic        w_pay_bit;

    // MSB-first CRC-8, polynomial 0x07, one bit per call
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? 8'h07 : 8'h00);
    endfunction

    assign w_acc      = s_tvalid & r_tready;
    assign w_loading  = (r_state == IDLE) || (r_state == LOAD);
    assign w_hdr_bit  = r_hdr[3'd7 - r_cnt[2:0]];
    assign w_pay_byte = r_buf[r_idx];
    assign w_pay_bit  = w_pay_byte[3'd7 - r_cnt[2:0]];

    always_ff @(posedge clk_32M768) begin
        if (w_acc && w_loading)
            r_buf[r_wr_ptr] <= s_tdata;
    end

    always_ff @(posedge clk_32M768) begin
        if (rst_32M768) begin
            r_state     <= IDLE;
            r_wr_ptr    <= 4'd0;
            r_len       <= 4'd0;
            r_idx       <= 4'd0;
            r_hdr       <= 8'h00;
            r_crc       <= 8'h00;
            r_cnt       <= 16'd0;
            r_tready    <= 1'b0;
            r_tx_serial <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_tx_sof    <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            case (r_state)
                IDLE, LOAD: begin
                    r_tready <= 1'b1;
                    if (w_acc) begin
                        if (s_tlast || (r_wr_ptr == 4'(MAX_LEN - 1))) begin
                            r_len    <= r_wr_ptr + 4'd1;
                            r_hdr    <= {MODE_CTRL, r_wr_ptr + 4'd1};
                            r_crc    <= 8'h00;
                            r_wr_ptr <= 4'd0;
                            r_idx    <= 4'd0;
                            r_cnt    <= 16'd0;
                            if (s_tlast) begin
                                r_state  <= SEND_PRE;
                                r_tready <= 1'b0;
                            end else begin
                                r_state <= DISCARD;
                                r_ovf   <= 1'b1;
                            end
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 4'd1;
                            r_state  <= LOAD;
                        end
                    end
                end
                DISCARD: begin
                    if (w_acc && s_tlast) begin
                        r_state  <= SEND_PRE;
                        r_tready <= 1'b0;
                    end
                end
                SEND_PRE: begin
                    if (sym_en) begin
                        r_tx_serial <= PREAMBLE[5'd31 - r_cnt[4:0]];
                        r_tx_valid  <= 1'b1;
                        r_tx_sof    <= (r_cnt == 16'd0);
                        if (r_cnt == 16'd31) begin
                            r_cnt   <= 16'd0;
                            r_state <= SEND_HDR;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                SEND_HDR: begin
                    if (sym_en) begin
                        r_tx_serial <= w_hdr_bit;
                        r_tx_sof    <= 1'b0;
                        r_crc       <= crc8_step(r_crc, w_hdr_bit);
                        if (r_cnt == 16'd7) begin
                            r_cnt   <= 16'd0;
                            r_state <= SEND_PAY;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                SEND_PAY: begin
                    if (sym_en) begin
                        r_tx_serial <= w_pay_bit;
                        r_crc       <= crc8_step(r_crc, w_pay_bit);
                        if (r_cnt == 16'd7) begin
                            r_cnt <= 16'd0;
                            if (r_idx == r_len - 4'd1)
                                r_state <= SEND_CRC;
                            else
                                r_idx <= r_idx + 4'd1;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                SEND_CRC: begin
                    // r_crc is no longer updated here, so it stays frozen while shifted out
                    if (sym_en) begin
                        r_tx_serial <= r_crc[3'd7 - r_cnt[2:0]];
                        if (r_cnt == 16'd7) begin
                            r_cnt   <= 16'd0;
                            r_state <= GAP;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                GAP: begin
                    if (sym_en) begin
                        r_tx_serial <= 1'b0;
                        r_tx_valid  <= 1'b0;
                        if (r_cnt == 16'(GAP_BITS - 1)) begin
                            r_cnt    <= 16'd0;
                            r_state  <= IDLE;
                            r_tready <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s_tready  = r_tready;
    assign tx_serial = r_tx_serial;
    assign tx_valid  = r_tx_valid;
    assign tx_sof    = r_tx_sof;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_tx_framer.sv
// Scoreboard bench for tx_framer: expected frame bits are queued when a packet closes
// and popped on every symbol strobe that produces a valid bit.
module tb_tx_framer;

    localparam logic [31:0] PRE = 32'h1ACF_FC1D;
    localparam int          GAP = 16;
    localparam int          TMO = 20000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sym_en = 1'b0;
    logic [3:0] mode = 4'd0;
    logic [7:0] s_tdata = 8'h00;
    logic       s_tvalid = 1'b0;
    logic       s_tlast = 1'b0;
    logic       s_tready, tx_serial, tx_valid, tx_sof, ovf;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] exp_q[$];
    int         exp_len[$];
    int         gap_q[$];
    logic [7:0] pkt [20];

    logic       se_q = 1'b0;
    logic       rst_q = 1'b1;
    logic [2:0] held = 3'b000;
    int         hi_run = 0;
    int         low_run = 0;
    logic       seen_end = 1'b0;
    int         ovf_cnt = 0;
    int         acc_cnt = 0;
    logic       sym_irr = 1'b0;

    tx_framer dut (
        .clk_32M768 (clk),
        .rst_32M768 (rst),
        .sym_en     (sym_en),
        .MODE_CTRL  (mode),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .tx_serial  (tx_serial),
        .tx_valid   (tx_valid),
        .tx_sof     (tx_sof),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    task automatic push_byte(input logic [7:0] b, input logic first);
        for (int i = 7; i >= 0; i--)
            exp_q.push_back({first && (i == 7), b[i]});
    endtask

    task automatic push_frame(input logic [3:0] m, input int n);
        logic [7:0] h;
        logic [7:0] c;
        h = {m, 4'(n)};
        c = crc8_byte(8'h00, h);
        for (int i = 31; i >= 0; i--)
            exp_q.push_back({i == 31, PRE[i]});
        push_byte(h, 1'b0);
        for (int i = 0; i < n; i++) begin
            push_byte(pkt[i], 1'b0);
            c = crc8_byte(c, pkt[i]);
        end
        push_byte(c, 1'b0);
        exp_len.push_back(48 + 8 * n);
    endtask

    // symbol strobe: every 32 clocks, or cycling through 1/2/37-clock spacings
    initial begin
        int gaps[3];
        int k;
        int g;
        gaps = '{1, 2, 37};
        k = 0;
        @(negedge clk);
        forever begin
            if (sym_irr) begin
                g = gaps[k % 3];
                k++;
            end else begin
                g = 32;
            end
            sym_en = 1'b1;
            @(negedge clk);
            if (g > 1) begin
                sym_en = 1'b0;
                repeat (g - 1) @(negedge clk);
            end
        end
    end

    always @(posedge clk) begin
        se_q  <= sym_en;
        rst_q <= rst;
        if (s_tvalid && s_tready && !rst)
            acc_cnt <= acc_cnt + 1;
    end

    always @(negedge clk) begin
        logic [1:0] e;
        if (rst || rst_q) begin
            hi_run   = 0;
            low_run  = 0;
            seen_end = 1'b0;
        end else if (se_q) begin
            if (tx_valid) begin
                if (seen_end && low_run > 0)
                    gap_q.push_back(low_run);
                low_run  = 0;
                seen_end = 1'b0;
                hi_run++;
                chk("bit_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("bit", 32'(tx_serial), 32'(e[0]));
                    chk("sof", 32'(tx_sof), 32'(e[1]));
                end
            end else begin
                if (hi_run > 0) begin
                    chk("frame_expected", 32'(exp_len.size() != 0), 32'd1);
                    if (exp_len.size() != 0)
                        chk("vld_len", 32'(hi_run), 32'(exp_len.pop_front()));
                    hi_run   = 0;
                    seen_end = 1'b1;
                end
                if (seen_end)
                    low_run++;
            end
        end else begin
            chk("hold", 32'({tx_valid, tx_sof, tx_serial}), 32'(held));
        end
        held = {tx_valid, tx_sof, tx_serial};
        if (ovf)
            ovf_cnt++;
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        exp_q.delete();
        exp_len.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", 32'({s_tready, tx_valid, tx_sof, tx_serial, ovf}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("tready_after_rst", 32'(s_tready), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int t;
        t = 0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = last;
        while (!s_tready && t < TMO) begin
            @(negedge clk);
            t++;
        end
        chk("hs_timeout", 32'(t < TMO), 32'd1);
        @(negedge clk);
    endtask

    task automatic send_pkt(input logic [3:0] m, input int n);
        mode = m;
        for (int i = 0; i < n; i++)
            send_byte(pkt[i], i == n - 1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        push_frame(m, n);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!(s_tready && exp_q.size() == 0) && t < TMO) begin
            @(negedge clk);
            t++;
        end
        chk("done_timeout", 32'(t < TMO), 32'd1);
    endtask

    initial begin
        int o0;
        int a0;
        int t;
        do_reset();

        // single zero byte, MIX: literal expected frame
        mode = 4'b0100;
        send_byte(8'h00, 1'b1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        begin
            logic [55:0] v;
            v = {32'h1ACFFC1D, 8'h41, 8'h00, 8'h4E};
            for (int i = 55; i >= 0; i--)
                exp_q.push_back({i == 55, v[i]});
            exp_len.push_back(56);
        end
        wait_done();

        // three bytes, QPSK; s_tready must stay low until the gap ends
        pkt[0] = 8'hA5; pkt[1] = 8'h5A; pkt[2] = 8'hFF;
        send_pkt(4'b0010, 3);
        chk("tready_busy", 32'(s_tready), 32'd0);
        wait_done();
        #1;
        chk("ready_after_gap", 32'(low_run), 32'(GAP));

        // 20-byte packet truncated at 15
        o0 = ovf_cnt;
        a0 = acc_cnt;
        mode = 4'b0001;
        for (int i = 0; i < 20; i++)
            pkt[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 20; i++) begin
            send_byte(pkt[i], i == 19);
            if (i == 14)
                push_frame(4'b0001, 15);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        chk("ovf_pulses", 32'(ovf_cnt - o0), 32'd1);
        chk("accepted", 32'(acc_cnt - a0), 32'd20);
        wait_done();
        pkt[0] = 8'h3C;
        send_pkt(4'b0100, 1);
        wait_done();

        // exactly MAX_LEN with tlast: no overflow
        o0 = ovf_cnt;
        for (int i = 0; i < 15; i++)
            pkt[i] = 8'(i * 17 + 3);
        send_pkt(4'b0010, 15);
        wait_done();
        chk("ovf_none", 32'(ovf_cnt - o0), 32'd0);

        // back-to-back with s_tvalid held high
        mode = 4'b0001;
        pkt[0] = 8'h11;
        send_byte(8'h11, 1'b1);
        push_frame(4'b0001, 1);
        pkt[0] = 8'h22;
        send_byte(8'h22, 1'b1);
        push_frame(4'b0001, 1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        wait_done();
        chk("gap_b2b", 32'(gap_q.size() != 0 ? gap_q[$] : 0), 32'(GAP));

        // reset during the payload, then a clean frame
        pkt[0] = 8'hDE; pkt[1] = 8'hAD; pkt[2] = 8'hBE; pkt[3] = 8'hEF;
        send_pkt(4'b0100, 4);
        t = 0;
        while (exp_q.size() > 24 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        chk("mid_wait", 32'(t < TMO), 32'd1);
        do_reset();
        pkt[0] = 8'h81; pkt[1] = 8'h7E;
        send_pkt(4'b0010, 2);
        wait_done();

        // irregular strobe spacing
        sym_irr = 1'b1;
        pkt[0] = 8'hC3; pkt[1] = 8'h96; pkt[2] = 8'h0F;
        send_pkt(4'b0001, 3);
        wait_done();
        sym_irr = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
